// File: rtl/pi_sequencer.sv
// Sequencer for the shared PI ALU: latches Error/Fwd on go, steps the ALU through
// integral, proportional and accumulate steps, and produces saturated left/right commands.
module pi_sequencer #(
  parameter logic [13:0] P_TERM  = 14'h3680,
  parameter logic [11:0] I_TERM  = 12'h500,
  parameter int          INT_DEC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [11:0] Error,
  input  logic [11:0] Fwd,
  input  logic [15:0] dst,
  output logic [11:0] err_lat,
  output logic [11:0] fwd_lat,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Icomp,
  output logic [11:0] Intgrl,
  output logic [11:0] Iterm,
  output logic [13:0] Pterm,
  output logic [2:0]  src1sel,
  output logic [2:0]  src0sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        busy,
  output logic        done
);

  localparam int CW = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INTG   = 4'd1,
    ICMP   = 4'd2,
    ICMP_W = 4'd3,
    PCMP   = 4'd4,
    PCMP_W = 4'd5,
    ACC_R  = 4'd6,
    RHT    = 4'd7,
    ACC_L  = 4'd8,
    LFT    = 4'd9,
    DONE   = 4'd10
  } state_t;

  typedef struct packed {
    logic [2:0] s1;
    logic [2:0] s0;
    logic       mul;
    logic       sb;
    logic       sat;
    logic       bsy;
    logic       dn;
  } ctrl_t;

  state_t        state_r, state_nxt_s;
  ctrl_t         ctrl_r;
  logic [CW-1:0] int_cnt_r, int_cnt_nxt_s;
  logic          int_upd_r;
  logic [11:0]   err_lat_r, fwd_lat_r, icomp_r, intgrl_r, lft_r, rht_r;
  logic [15:0]   accum_r, pcomp_r;

  // ALU controls that belong to each state; multiply steps span both halves of the pair
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = ctrl_t'(11'd0);
    case (s)
      IDLE:   c = ctrl_t'(11'd0);
      INTG:   begin c.s1 = 3'b011; c.s0 = 3'b001; c.sat = 1'b1; c.bsy = 1'b1; end
      ICMP,
      ICMP_W: begin c.s1 = 3'b001; c.s0 = 3'b001; c.mul = 1'b1; c.bsy = 1'b1; end
      PCMP,
      PCMP_W: begin c.s1 = 3'b010; c.s0 = 3'b100; c.mul = 1'b1; c.bsy = 1'b1; end
      ACC_R:  begin c.s1 = 3'b100; c.s0 = 3'b011; c.sb = 1'b1; c.bsy = 1'b1; end
      RHT:    begin c.s1 = 3'b000; c.s0 = 3'b010; c.sb = 1'b1; c.sat = 1'b1; c.bsy = 1'b1; end
      ACC_L:  begin c.s1 = 3'b100; c.s0 = 3'b011; c.bsy = 1'b1; end
      LFT:    begin c.s1 = 3'b000; c.s0 = 3'b010; c.sat = 1'b1; c.bsy = 1'b1; end
      DONE:   begin c.bsy = 1'b1; c.dn = 1'b1; end
      default: c = ctrl_t'(11'd0);
    endcase
    return c;
  endfunction

  // Next-state sequencing and integrator decimation count
  always_comb begin
    state_nxt_s = state_r;
    if (int_cnt_r == CW'(INT_DEC - 1)) begin
      int_cnt_nxt_s = {CW{1'b0}};
    end else begin
      int_cnt_nxt_s = int_cnt_r + CW'(1);
    end
    case (state_r)
      IDLE: begin
        if (go) begin
          state_nxt_s = INTG;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INTG:    state_nxt_s = ICMP;
      ICMP:    state_nxt_s = ICMP_W;
      ICMP_W:  state_nxt_s = PCMP;
      PCMP:    state_nxt_s = PCMP_W;
      PCMP_W:  state_nxt_s = ACC_R;
      ACC_R:   state_nxt_s = RHT;
      RHT:     state_nxt_s = ACC_L;
      ACC_L:   state_nxt_s = LFT;
      LFT:     state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; controls are registered from the next state so they switch only on edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ctrl_r  <= ctrl_t'(11'd0);
    end else begin
      state_r <= state_nxt_s;
      ctrl_r  <= ctrl_of(state_nxt_s);
    end
  end

  // Input latches and working registers, each captured at the final edge of its state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_lat_r <= 12'd0;
      fwd_lat_r <= 12'd0;
      int_cnt_r <= {CW{1'b0}};
      int_upd_r <= 1'b0;
      intgrl_r  <= 12'd0;
      icomp_r   <= 12'd0;
      pcomp_r   <= 16'd0;
      accum_r   <= 16'd0;
      rht_r     <= 12'd0;
      lft_r     <= 12'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (go) begin
            err_lat_r <= Error;
            fwd_lat_r <= Fwd;
            int_cnt_r <= int_cnt_nxt_s;
            int_upd_r <= (int_cnt_nxt_s == {CW{1'b0}});
          end
        end
        INTG: begin
          if (int_upd_r) intgrl_r <= dst[11:0];
        end
        ICMP_W:       icomp_r <= dst[11:0];
        PCMP_W:       pcomp_r <= dst;
        ACC_R, ACC_L: accum_r <= dst;
        RHT:          rht_r   <= dst[11:0];
        LFT:          lft_r   <= dst[11:0];
        default:      ;
      endcase
    end
  end

  assign err_lat  = err_lat_r;
  assign fwd_lat  = fwd_lat_r;
  assign Accum    = accum_r;
  assign Pcomp    = pcomp_r;
  assign Icomp    = icomp_r;
  assign Intgrl   = intgrl_r;
  assign lft      = lft_r;
  assign rht      = rht_r;
  assign Iterm    = I_TERM;
  assign Pterm    = P_TERM;
  assign src1sel  = ctrl_r.s1;
  assign src0sel  = ctrl_r.s0;
  assign multiply = ctrl_r.mul;
  assign sub      = ctrl_r.sb;
  assign saturate = ctrl_r.sat;
  assign busy     = ctrl_r.bsy;
  assign done     = ctrl_r.dn;
  assign mult2    = 1'b0;
  assign mult4    = 1'b0;

endmodule

// File: doc/pi_sequencer.md
# pi_sequencer

Sequencer for the shared PI ALU in the line-follower motor controller. On each `go` it latches the current line `Error` and forward speed `Fwd`. It then walks the ALU through the integral, proportional and accumulate steps, capturing each `dst` into working registers, and produces saturated 12-bit left/right motor commands with a single `done` pulse. It owns every ALU operand register and control input, so the ALU remains purely combinational.

## Interface
- `P_TERM`, default 14'h3680: proportional gain, driven on `Pterm`.
- `I_TERM`, default 12'h500: integral gain, driven on `Iterm`.
- `INT_DEC`, default 4: the integrator updates once per `INT_DEC` accepted `go`s. Must be a power of 2.

Ports:
- `clk` input 1: single clock. All logic updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `go` input 1: start one PI computation. Sampled only in IDLE.
- `Error` input 12: signed line error.
- `Fwd` input 12: unsigned forward speed.
- `dst` input 16: ALU result.
- `err_lat`, `fwd_lat` output 12: latched copies, driven to the ALU `Error`/`Fwd` inputs.
- `Accum`, `Pcomp` output 16: working registers, driven to the ALU.
- `Icomp`, `Intgrl` output 12: working registers, driven to the ALU.
- `Iterm` output 12, `Pterm` output 14: the constants `I_TERM`/`P_TERM`.
- `src1sel`, `src0sel` output 3: ALU operand selects.
- `multiply`, `sub`, `mult2`, `mult4`, `saturate` output 1: ALU controls. `mult2`/`mult4` are tied 0.
- `lft`, `rht` output 12: signed saturated motor commands.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a computation completes.

## Operation
- Select encodings:
  - src1: Accum=000, Iterm=001, Err=010, Err>>4=011, Fwd=100.
  - src0: A2D=000, Intgrl=001, Icomp=010, Pcomp=011, Pterm=100.
- In IDLE the selects are 000/000 and all controls are 0.
- IDLE, `go`=1: latch `err_lat`←`Error` and `fwd_lat`←`Fwd`, increment `int_cnt` (mod `INT_DEC`), then enter INTG.
- States, each capturing `dst` at its final edge:
  - INTG (src1 011, src0 001, saturate): `Intgrl`←`dst[11:0]`, written only when `int_cnt`==0 after the increment. Otherwise nothing is written.
  - ICMP, then ICMP_W (src1 001, src0 001, multiply; controls held 2 cycles as a multicycle path): at the end of ICMP_W, `Icomp`←`dst[11:0]`.
  - PCMP, then PCMP_W (src1 010, src0 100, multiply; held 2 cycles): `Pcomp`←`dst`.
  - ACC_R (src1 100, src0 011, sub): `Accum`←`dst`, giving Fwd−Pcomp.
  - RHT (src1 000, src0 010, sub, saturate): `rht`←`dst[11:0]`.
  - ACC_L (src1 100, src0 011): `Accum`←`dst`, giving Fwd+Pcomp.
  - LFT (src1 000, src0 010, saturate): `lft`←`dst[11:0]`.
  - DONE: `done`=1 for this cycle, then return to IDLE.
- `go` outside IDLE is ignored. It is neither queued nor counted.
- `lft`/`rht` hold their value until overwritten. `Intgrl` persists across computations and is cleared only by reset.
- Any state encoding not listed above returns to IDLE.

## Timing
- `go` is sampled at edge 0. INTG occupies cycle 1, ICMP/ICMP_W cycles 2–3, PCMP/PCMP_W cycles 4–5, ACC_R 6, RHT 7, ACC_L 8, LFT 9.
- `done` is high in cycle 10, and `rht`/`lft` are valid from cycles 8/10 onward.
- The earliest next accepted `go` is sampled at the end of cycle 11, which is the first IDLE cycle.
- Fixed latency: 10 cycles from `go` to `done`, with or without an integrator update.
- Controls change only on clock edges. Every operand register feeding a multiply is stable for the full 2 cycles.
- Reset:
  - State returns to IDLE.
  - `Accum`, `Pcomp`, `Icomp`, `Intgrl`, `err_lat`, `fwd_lat`, `lft`, `rht` and `int_cnt` are all cleared to 0.
  - `busy`=0, `done`=0, selects 000, controls 0.
  - Reset asserted mid-sequence takes effect at the next edge. No `done` is produced and partial results are discarded.
- `rst_n` and `go` asserted in the same cycle: reset wins and `go` is dropped.

## Test plan
- After reset, `Error`=0, `Fwd`=0x100, `go` pulse -> `busy` for cycles 1–10, `done` only in cycle 10, `rht`=`lft`=0x100, `Pcomp`=`Icomp`=0.
- First `go` after reset, `Error`=0x010, `Fwd`=0x200 -> `Pcomp`=0x0036, `Intgrl` unchanged at 0, `Icomp`=0, `rht`=0x1CA, `lft`=0x236.
- `Error`=0x7F0 held, `go` repeated -> `Intgrl`=0x07F after the 4th `go`, 0x0FE after the 8th, and saturates at 0x7FF from the 68th onward (never wraps).
- `Error`=0, `Fwd`=0xFFF -> `Accum`=0x0FFF, `lft`=`rht`=0x7FF.
- `go` pulsed in cycles 3 and 9 of a sequence -> ignored. `int_cnt` is not incremented, only one `done` appears, and `err_lat` is unchanged.
- `rst_n` low in PCMP_W -> IDLE at the next edge, all outputs 0, no `done`. A fresh `go` afterwards completes in exactly 10 cycles.
